sparse_index_encoder: RTL and testbench
=======================================

// Module: sparse_index_encoder
// PURPOSE
//  Compresses a dense stream of activation/weight elements into the zero-run sparse format
//  consumed by coordinatecomputation.
//  - Accepts one dense element per cycle and keeps the nonzero ones.
//  - Each kept value gets a 4-bit relative index.
//  - Emits groups of 16/8/4 entries, selected by the bitwidth mode of 2/4/8.
//  - Sits between the layer-output writeback and the sparse buffer that feeds the PE array.
// PARAMETERS
//  DATA_W    8   element width in bits
//  MAX_LANES 16  output slots; fixed by the 2-bit mode
// PORTS
//  clk          in   1           clock
//  reset_n      in   1           async active-low reset
//  bitwidth     in   4           4'b0010->16 lanes, 4'b0100->8, 4'b1000->4; other codes: in_ready stays 0
//  in_valid     in   1           dense element valid
//  in_ready     out  1           encoder can accept an element
//  in_data      in   DATA_W      dense element (0 = zero)
//  in_last      in   1           last element of the tile
//  out_valid    out  1           compressed group valid
//  out_ready    in   1           downstream accepts the group
//  out_values   out  16*DATA_W   slot k value at [k*DATA_W +: DATA_W]
//  out_indices  out  64          slot k index at [k*4 +: 4]
//  out_count    out  5           number of real entries in the group, 0..N
//  out_last     out  1           group closes the tile
// BEHAVIOUR
//  Reset: all outputs 0; run=0; slot=0; first=1; state=ACCUM.
//  Mode: N is latched from bitwidth on the first accepted element of a tile. Changes mid-tile are ignored.
//  States:
//  - ACCUM: in_ready=1 (legal mode). Accepts an element when in_valid && in_ready.
//  - HOLD:  in_ready=0; out_valid=1. Holds the group until out_ready, then returns to ACCUM.
//  Index encoding. run = zeros accepted since the previous entry. For slot k:
//  - k=0 && first: idx = run
//  - k=0 && !first: idx = run+1
//  - k>0: idx = run
//  - Decoder check: abs[0] = prev_last + idx, abs[k] = abs[k-1] + idx + 1.
//  Slot limit: lim = 14 if (k=0 && !first), else 15.
//  Per accepted element:
//  - nonzero: write {in_data, idx} to slot; slot++; run=0.
//  - zero && run==lim: write explicit entry {0, idx}; slot++; run=0.
//  - zero otherwise: run++.
//  Group close:
//  - when slot reaches N, or when in_last is accepted.
//  - Next cycle: out_* registered; out_count=slot; state=HOLD; slot=0.
//  - first clears after the first closed group of a tile; in_last sets it again.
//  Tile end (in_last):
//  - Trailing zeros are dropped.
//  - Always emits a final group with out_last=1, even if out_count=0.
//  - run resets to 0.
//  - If the in_last element itself fills slot N: one group, out_last=1.
//  Unused slots (k >= out_count): value 0, idx 0.
//  Latency: group output valid 1 cycle after its closing element is accepted.
//  Throughput: 1 element/cycle except HOLD cycles (at least 1 per group).
//  out_* are stable while out_valid && !out_ready.
//  Async reset mid-operation discards any partial group and held group.
// TESTING
//  1. mode 4'b1000, stream 5,0,0,7,3,0,9 (last on 9)
//     -> group1 vals{5,7,3,9} idx{0,2,0,1} count4 last1.
//  2. mode 4'b1000, 8 nonzero 1..8, last on 8
//     -> group1 idx{0,0,0,0} last0; group2 vals{5..8} idx{1,0,0,0} last1.
//  3. mode 4'b0100, 20 zeros then 4, last
//     -> entries {0,idx15},{4,idx4}; count2 last1.
//  4. mode 4'b0010, zeros only with last on 10th element
//     -> single group count0 last1.
//  5. out_ready held 0 for 5 cycles with group pending
//     -> in_ready=0, out_* unchanged; in_valid elements not consumed.
//  6. reset_n pulsed low mid-group after 3 entries
//     -> all outputs 0 same cycle; next tile slot0 idx = absolute position.

Source files
------------

// File: rtl/sparse_index_encoder.sv
// Zero-run sparse encoder: packs nonzero dense elements into groups of 16/8/4
// {value, 4-bit relative index} entries, one group per handshake on the output side.
module sparse_index_encoder #(
    parameter int DATA_W    = 8,
    parameter int MAX_LANES = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [3:0]                    bitwidth,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_W-1:0]             in_data,
    input  logic                          in_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [MAX_LANES*DATA_W-1:0]   out_values,
    output logic [MAX_LANES*4-1:0]        out_indices,
    output logic [4:0]                    out_count,
    output logic                          out_last
);

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t                      state;
    logic [4:0]                  slot, slot_nxt, lanes_q, mode_lanes, eff_lanes;
    logic [3:0]                  run, idx, lim;
    logic                        first, tile_open, cont, write, accept, close;
    logic [DATA_W-1:0]           slot_val [MAX_LANES];
    logic [3:0]                  slot_idx [MAX_LANES];
    logic [MAX_LANES*DATA_W-1:0] grp_values;
    logic [MAX_LANES*4-1:0]      grp_indices;

    always_comb begin
        case (bitwidth)
            4'b0010: mode_lanes = 5'd16;
            4'b0100: mode_lanes = 5'd8;
            4'b1000: mode_lanes = 5'd4;
            default: mode_lanes = 5'd0;
        endcase
    end

    // Group size is frozen once a tile has started; only the opening element sees bitwidth.
    assign eff_lanes = tile_open ? lanes_q : mode_lanes;
    assign in_ready  = reset_n && (state == ACCUM) && (eff_lanes != 5'd0);
    assign accept    = in_valid && in_ready;

    // Slot 0 of a continuation group counts from the previous group's last entry, hence +1.
    assign cont     = (slot == 5'd0) && !first;
    assign lim      = cont ? 4'd14 : 4'd15;
    assign idx      = run + {3'd0, cont};
    assign write    = (in_data != '0) || (run == lim);
    assign slot_nxt = slot + {4'd0, write};
    assign close    = accept && ((slot_nxt == eff_lanes) || in_last);

    // NOTE: every output of this block gets its default before the conditional override, so no latch.
    always_comb begin
        for (int k = 0; k < MAX_LANES; k++) begin
            grp_values[k*DATA_W +: DATA_W] = slot_val[k];
            grp_indices[k*4 +: 4]          = slot_idx[k];
            if (write && (slot == 5'(k))) begin
                grp_values[k*DATA_W +: DATA_W] = in_data;
                grp_indices[k*4 +: 4]          = idx;
            end
        end
    end

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ACCUM;
            slot        <= 5'd0;
            run         <= 4'd0;
            first       <= 1'b1;
            tile_open   <= 1'b0;
            lanes_q     <= 5'd0;
            out_valid   <= 1'b0;
            out_values  <= '0;
            out_indices <= '0;
            out_count   <= 5'd0;
            out_last    <= 1'b0;
            // NOTE: slot storage is reset because unused output slots must read as zero.
            for (int k = 0; k < MAX_LANES; k++) begin
                slot_val[k] <= '0;
                slot_idx[k] <= '0;
            end
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        tile_open <= !in_last;
                        if (!tile_open) lanes_q <= mode_lanes;
                        if (close) begin
                            out_values  <= grp_values;
                            out_indices <= grp_indices;
                            out_count   <= slot_nxt;
                            out_last    <= in_last;
                            out_valid   <= 1'b1;
                            state       <= HOLD;
                            slot        <= 5'd0;
                            run         <= 4'd0;
                            first       <= in_last;
                            for (int k = 0; k < MAX_LANES; k++) begin
                                slot_val[k] <= '0;
                                slot_idx[k] <= '0;
                            end
                        end else if (write) begin
                            slot_val[slot[3:0]] <= in_data;
                            slot_idx[slot[3:0]] <= idx;
                            slot                <= slot_nxt;
                            run                 <= 4'd0;
                        end else begin
                            run <= run + 4'd1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ACCUM;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sparse_index_encoder.sv
// Self-checking bench for sparse_index_encoder: directed scenarios plus random tiles
// compared against a position-based reference model.
module tb_sparse_index_encoder;

    localparam int DATA_W = 8;

    typedef struct packed {
        logic [127:0] vals;
        logic [63:0]  idxs;
        logic [4:0]   cnt;
        logic         last;
    } grp_t;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [3:0]   bitwidth;
    logic         in_valid, in_ready, in_last, out_valid, out_ready, out_last;
    logic [7:0]   in_data;
    logic [127:0] out_values;
    logic [63:0]  out_indices;
    logic [4:0]   out_count;

    int   errors = 0;
    int   checks = 0;
    int   tile_q[$];
    grp_t exp_q[$];
    grp_t got_q[$];

    always #5 clk = ~clk;

    sparse_index_encoder #(.DATA_W(DATA_W), .MAX_LANES(16)) dut (
        .clk(clk), .reset_n(reset_n), .bitwidth(bitwidth),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_values(out_values),
        .out_indices(out_indices), .out_count(out_count), .out_last(out_last)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int lanes_of(input logic [3:0] bw);
        return (bw == 4'b0010) ? 16 : (bw == 4'b0100) ? 8 : 4;
    endfunction

    // Reference: decide which positions become entries, then chunk and derive indices
    // from position differences as a downstream decoder would reconstruct them.
    task automatic build_expected(input int lanes);
        int   pos_q[$];
        int   val_q[$];
        int   n, ng, prev, gap_idx, lo, hi, s, pidx;
        bit   cnt_cont;
        grp_t g;
        exp_q.delete();
        for (int i = 0; i < tile_q.size(); i++) begin
            cnt_cont = (pos_q.size() > 0) && (pos_q.size() % lanes == 0);
            prev     = (pos_q.size() > 0) ? pos_q[$] : -1;
            gap_idx  = i - prev - 1 + int'(cnt_cont);
            if (tile_q[i] != 0 || gap_idx == 15) begin
                pos_q.push_back(i);
                val_q.push_back(tile_q[i]);
            end
        end
        n  = pos_q.size();
        ng = (n + lanes - 1) / lanes;
        if (n == 0) ng = 1;
        else if (n % lanes == 0 && pos_q[$] != tile_q.size() - 1) ng++;
        for (int gi = 0; gi < ng; gi++) begin
            g  = '0;
            lo = gi * lanes;
            hi = (n < lo + lanes) ? n : lo + lanes;
            for (int e = lo; e < hi; e++) begin
                s    = e - lo;
                prev = (e == 0) ? -1 : pos_q[e-1];
                pidx = pos_q[e] - prev - 1 + ((s == 0 && e > 0) ? 1 : 0);
                g.vals[s*8 +: 8] = 8'(val_q[e]);
                g.idxs[s*4 +: 4] = 4'(pidx);
            end
            g.cnt  = 5'((hi > lo) ? hi - lo : 0);
            g.last = (gi == ng - 1);
            exp_q.push_back(g);
        end
    endtask

    // Streams tile_q into the DUT and collects every group handed over downstream.
    task automatic run_tile(input logic [3:0] bw, input int rdy_pct, input int vld_pct, input bit scramble);
        int sent = 0;
        int cyc  = 0;
        bit done = 0;
        bit acc;
        got_q.delete();
        bitwidth = bw;
        while (!done && cyc < 4000) begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 99) < rdy_pct);
            if (out_valid && out_ready) begin
                got_q.push_back({out_values, out_indices, out_count, out_last});
                if (out_last) done = 1;
            end
            in_valid = (sent < tile_q.size()) && ($urandom_range(0, 99) < vld_pct);
            in_data  = (sent < tile_q.size()) ? 8'(tile_q[sent]) : 8'd0;
            in_last  = (sent == tile_q.size() - 1);
            if (scramble && sent > 0 && sent < tile_q.size()) bitwidth = 4'($urandom_range(0, 15));
            #1;
            acc = in_valid && in_ready;
            @(posedge clk);
            if (acc) sent++;
            cyc++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("tile completes within budget", done, 1'b1);
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic l, input logic r, output bit acc);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        out_ready = r;
        #1;
        acc = v && in_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic check_group(input string tag, input int gi, input logic [127:0] v,
                               input logic [63:0] x, input logic [4:0] c, input logic l);
        if (gi < got_q.size()) begin
            check({tag, " vals"},  got_q[gi].vals, v);
            check({tag, " idxs"},  got_q[gi].idxs, x);
            check({tag, " count"}, got_q[gi].cnt,  c);
            check({tag, " last"},  got_q[gi].last, l);
        end
    endtask

    initial begin
        bit          acc;
        int          lanes, zpct, len;
        logic [3:0]  bw;
        logic [127:0] held;

        reset_n = 1'b0; bitwidth = 4'b1000; in_valid = 0; in_data = 0; in_last = 0; out_ready = 0;
        #1;
        check("reset outputs", {out_valid, out_last, out_count, in_ready, out_values, out_indices}, '0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        #1;
        check("ready after reset", in_ready, 1'b1);

        bitwidth = 4'b0000; #1;
        check("illegal mode 0000 blocks input", in_ready, 1'b0);
        bitwidth = 4'b0110; #1;
        check("illegal mode 0110 blocks input", in_ready, 1'b0);

        tile_q = '{5, 0, 0, 7, 3, 0, 9};
        run_tile(4'b1000, 100, 100, 0);
        check("t1 ngroups", got_q.size(), 1);
        check_group("t1 g0", 0, 128'h09030705, 64'h1020, 5'd4, 1'b1);

        tile_q = '{1, 2, 3, 4, 5, 6, 7, 8};
        run_tile(4'b1000, 100, 100, 0);
        check("t2 ngroups", got_q.size(), 2);
        check_group("t2 g0", 0, 128'h04030201, 64'h0000, 5'd4, 1'b0);
        check_group("t2 g1", 1, 128'h08070605, 64'h0001, 5'd4, 1'b1);

        tile_q.delete();
        repeat (20) tile_q.push_back(0);
        tile_q.push_back(4);
        run_tile(4'b0100, 100, 100, 0);
        check("t3 ngroups", got_q.size(), 1);
        check_group("t3 g0", 0, 128'h0400, 64'h4F, 5'd2, 1'b1);

        tile_q.delete();
        repeat (10) tile_q.push_back(0);
        run_tile(4'b0010, 100, 100, 0);
        check("t4 ngroups", got_q.size(), 1);
        check_group("t4 g0", 0, 128'h0, 64'h0, 5'd0, 1'b1);

        bitwidth = 4'b1000;
        for (int i = 1; i <= 4; i++) begin
            acc = 0;
            for (int t = 0; t < 20 && !acc; t++) drive(1, 8'(i), 0, 0, acc);
        end
        check("t5 group valid one cycle after close", {out_valid, out_count}, {1'b1, 5'd4});
        held = out_values;
        for (int t = 0; t < 5; t++) begin
            drive(1, 8'd5, 1, 0, acc);
            check("t5 input stalled in hold", acc, 1'b0);
            check("t5 outputs stable", {out_valid, out_values, out_indices, out_count}, {1'b1, held, 64'h0, 5'd4});
        end
        drive(1, 8'd5, 1, 1, acc);
        check("t5 handshake cycle not accepting", {acc, out_valid}, 2'b00);
        drive(1, 8'd5, 1, 1, acc);
        check("t5 pending element accepted", acc, 1'b1);
        check("t5 final group", {out_valid, out_values, out_indices, out_count, out_last},
              {1'b1, 128'h05, 64'h1, 5'd1, 1'b1});
        drive(0, 8'd0, 0, 1, acc);

        bitwidth = 4'b0100;
        drive(1, 8'h11, 0, 1, acc);
        drive(1, 8'h22, 0, 1, acc);
        drive(1, 8'h33, 0, 1, acc);
        @(negedge clk);
        in_valid = 0;
        reset_n  = 1'b0;
        #1;
        check("t6 async reset clears outputs",
              {out_valid, out_last, out_count, in_ready, out_values, out_indices}, '0);
        @(negedge clk) reset_n = 1'b1;
        tile_q = '{0, 0, 0, 9};
        run_tile(4'b0100, 100, 100, 0);
        check("t6 ngroups", got_q.size(), 1);
        check_group("t6 g0", 0, 128'h09, 64'h3, 5'd1, 1'b1);

        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 2))
                0:       bw = 4'b0010;
                1:       bw = 4'b0100;
                default: bw = 4'b1000;
            endcase
            lanes = lanes_of(bw);
            case ($urandom_range(0, 2))
                0:       zpct = 30;
                1:       zpct = 70;
                default: zpct = 97;
            endcase
            len = $urandom_range(1, 40);
            tile_q.delete();
            for (int i = 0; i < len; i++)
                tile_q.push_back(($urandom_range(0, 99) < zpct) ? 0 : int'($urandom_range(1, 255)));
            build_expected(lanes);
            run_tile(bw, $urandom_range(50, 100), $urandom_range(60, 100), 1);
            check($sformatf("rand t%0d ngroups", t), got_q.size(), exp_q.size());
            for (int gi = 0; gi < got_q.size() && gi < exp_q.size(); gi++)
                check($sformatf("rand t%0d g%0d", t, gi), got_q[gi], exp_q[gi]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
